sc_regseq_controller: RTL

- Sequences the random-shifter / general-register datapath.
- Takes debounced active-low clear/load requests and an optional auto-reload enable.
- Runs the shifter for a fixed number of cycles, then issues a one-cycle active-low load strobe to the general register.
- Issues one-cycle active-low clear strobes; clear always has priority. Sits between the debouncers and the SC_RegSHIFTER/SC_RegGENERAL pair, replacing the simple state machine.

---
 rtl/sc_regseq_pkg.sv | 35 +++
 rtl/sc_regseq_timer.sv | 36 +++
 rtl/sc_regseq_controller.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sc_regseq_pkg.sv
// Shared definitions for the shifter/general-register sequencer:
// state encoding and counter-width helpers.
package sc_regseq_pkg;

    // State encodings
    localparam logic [1:0] LP_IDLE  = 2'd0;
    localparam logic [1:0] LP_SHIFT = 2'd1;
    localparam logic [1:0] LP_LOAD  = 2'd2;
    localparam logic [1:0] LP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = LP_IDLE,
        ST_SHIFT = LP_SHIFT,
        ST_LOAD  = LP_LOAD,
        ST_CLEAR = LP_CLEAR
    } state_t;

    // Ceiling log2: number of bits needed to encode value distinct codes.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of a counter holding 0 .. n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sc_regseq_timer.sv
// Auto-reload period counter. Counts 0..AUTO_PERIOD-1 while enabled and
// flags a tick on the wrap cycle; disable or i_zero holds it at 0.
module sc_regseq_timer
#(
    parameter int AUTO_PERIOD = 1000,
    parameter int WIDTH       = 10
)
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_zero,
    output logic o_tick
);

    localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(AUTO_PERIOD - 1);

    logic [WIDTH-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == LP_LAST);
    // A forced zero (clear in progress) suppresses the tick as well.
    assign o_tick    = i_enable & ~i_zero & w_at_last;

    // Period counter with synchronous zero and wrap at AUTO_PERIOD-1
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_zero || !i_enable || w_at_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sc_regseq_controller.sv
// Sequencer for the random shifter / general register pair. Turns
// debounced clear/load requests (plus optional periodic auto loads) into
// a SHIFT_CYCLES-long shift window followed by a one-cycle load strobe,
// or a one-cycle clear strobe. Clear always wins.
module sc_regseq_controller
    import sc_regseq_pkg::*;
#(
    parameter int SHIFT_CYCLES = 8,
    parameter int AUTO_PERIOD  = 1000,
    parameter int COUNT_WIDTH  = 8
)
(
    input  logic                   SC_REGSEQ_CLOCK_50,
    input  logic                   SC_REGSEQ_RESET_InLow,
    input  logic                   SC_REGSEQ_clear_InLow,
    input  logic                   SC_REGSEQ_load_InLow,
    input  logic                   SC_REGSEQ_auto_In,
    output logic                   SC_REGSEQ_shiftEnable_Out,
    output logic                   SC_REGSEQ_clear_OutLow,
    output logic                   SC_REGSEQ_load_OutLow,
    output logic                   SC_REGSEQ_busy_Out,
    output logic [COUNT_WIDTH-1:0] SC_REGSEQ_loadCount_OutBUS
);

    localparam int LP_SHIFT_W = cnt_width(SHIFT_CYCLES);
    localparam int LP_TIMER_W = cnt_width(AUTO_PERIOD);
    localparam logic [LP_SHIFT_W-1:0] LP_SHIFT_LAST = LP_SHIFT_W'(SHIFT_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [LP_SHIFT_W-1:0]  r_shift_cnt;
    logic [LP_SHIFT_W-1:0]  w_shift_cnt_next;
    logic                   r_pending;
    logic                   w_pending_next;
    logic [COUNT_WIDTH-1:0] r_load_count;
    logic [COUNT_WIDTH-1:0] w_load_count_next;
    logic                   r_clear_hist;
    logic                   r_load_hist;

    logic w_clear_req;
    logic w_load_req;
    logic w_auto_tick;
    logic w_start_req;
    logic w_timer_zero;

    // A request is the first clock edge at which the input is seen low.
    assign w_clear_req  = r_clear_hist & ~SC_REGSEQ_clear_InLow;
    assign w_load_req   = r_load_hist  & ~SC_REGSEQ_load_InLow;
    assign w_start_req  = w_load_req | w_auto_tick;
    assign w_timer_zero = (r_state == ST_CLEAR);

    sc_regseq_timer #(
        .AUTO_PERIOD (AUTO_PERIOD),
        .WIDTH       (LP_TIMER_W)
    ) u_timer (
        .i_clk    (SC_REGSEQ_CLOCK_50),
        .i_rst_n  (SC_REGSEQ_RESET_InLow),
        .i_enable (SC_REGSEQ_auto_In),
        .i_zero   (w_timer_zero),
        .o_tick   (w_auto_tick)
    );

    // Edge-detect history of the request inputs
    always_ff @(posedge SC_REGSEQ_CLOCK_50 or negedge SC_REGSEQ_RESET_InLow) begin
        if (!SC_REGSEQ_RESET_InLow) begin
            r_clear_hist <= 1'b1;
            r_load_hist  <= 1'b1;
        end else begin
            r_clear_hist <= SC_REGSEQ_clear_InLow;
            r_load_hist  <= SC_REGSEQ_load_InLow;
        end
    end

    // FSM and datapath state registers
    always_ff @(posedge SC_REGSEQ_CLOCK_50 or negedge SC_REGSEQ_RESET_InLow) begin
        if (!SC_REGSEQ_RESET_InLow) begin
            r_state      <= ST_IDLE;
            r_shift_cnt  <= '0;
            r_pending    <= 1'b0;
            r_load_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_shift_cnt  <= w_shift_cnt_next;
            r_pending    <= w_pending_next;
            r_load_count <= w_load_count_next;
        end
    end

    // Next-state logic; a clear request overrides whatever the state decided
    always_comb begin
        w_state_next      = r_state;
        w_shift_cnt_next  = r_shift_cnt;
        w_pending_next    = r_pending;
        w_load_count_next = r_load_count;

        case (r_state)
            ST_IDLE: begin
                if (w_start_req || r_pending) begin
                    w_state_next     = ST_SHIFT;
                    w_shift_cnt_next = LP_SHIFT_LAST;
                    w_pending_next   = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (w_start_req) begin
                    w_pending_next = 1'b1;
                end
                if (r_shift_cnt == '0) begin
                    w_state_next = ST_LOAD;
                end else begin
                    w_shift_cnt_next = r_shift_cnt - LP_SHIFT_W'(1);
                end
            end
            ST_LOAD: begin
                if (r_load_count != '1) begin
                    w_load_count_next = r_load_count + COUNT_WIDTH'(1);
                end
                // A request arriving now is queued; an older one restarts SHIFT
                w_pending_next = w_start_req;
                if (r_pending) begin
                    w_state_next     = ST_SHIFT;
                    w_shift_cnt_next = LP_SHIFT_LAST;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_load_count_next = '0;
                w_pending_next    = 1'b0;
                w_state_next      = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Clear aborts any sequence; a simultaneous load is discarded
        if (w_clear_req) begin
            w_state_next   = ST_CLEAR;
            w_pending_next = 1'b0;
        end
    end

    assign SC_REGSEQ_shiftEnable_Out  = (r_state == ST_SHIFT);
    assign SC_REGSEQ_clear_OutLow     = (r_state != ST_CLEAR);
    assign SC_REGSEQ_load_OutLow      = (r_state != ST_LOAD);
    assign SC_REGSEQ_busy_Out         = (r_state != ST_IDLE);
    assign SC_REGSEQ_loadCount_OutBUS = r_load_count;

endmodule
